mmio_pwm_led_periph: RTL

//  Memory-mapped responder on the core's data-store bus (MemWrite/DataAdr/WriteData).

---
 rtl/mmio_pwm_led_periph.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mmio_pwm_led_periph.sv
// Memory-mapped LED register plus NUM_CH PWM channels that share one period counter.
// PERIOD and DUTY writes land in shadow registers. They move into the active set only when it is safe to do so.
module mmio_pwm_led_periph #(
   parameter logic [31:0]      BASE_ADDR  = 32'h0000_0100,
   parameter int               NUM_CH     = 4,
   parameter int               CNT_W      = 16,
   parameter logic [CNT_W-1:0] PERIOD_RST = 16'd999
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic [31:0]       DataAdr,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              hit,
   output logic [3:0]        leds,
   output logic [NUM_CH-1:0] pwm_out
);
   localparam int NREG = 4 + NUM_CH;

   logic [29:0]      word_off;
   logic [3:0]       widx;
   logic             wr, we_led, we_ctrl, we_period, clr, wrap, load_act;
   logic [3:0]       leds_q, leds_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      wraps_q, wraps_d;
   logic [CNT_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
   logic [CNT_W-1:0] duty_sh_q [NUM_CH];
   logic [CNT_W-1:0] duty_act_q [NUM_CH];
   logic [NUM_CH-1:0] pwm_q;
   logic             unused_ok;

   // Decode on word addresses so the byte-lane bits never affect the hit window.
   assign word_off  = DataAdr[31:2] - BASE_ADDR[31:2];
   assign hit       = (DataAdr[31:2] >= BASE_ADDR[31:2]) && (word_off < 30'(NREG));
   assign widx      = word_off[3:0];
   assign wr        = MemWrite && hit;
   assign we_led    = wr && (widx == 4'd0);
   assign we_ctrl   = wr && (widx == 4'd1);
   assign we_period = wr && (widx == 4'd2);
   assign unused_ok = ^{DataAdr[1:0], WriteData[31:CNT_W]};

   always_comb begin
      leds_d      = we_led ? WriteData[3:0] : leds_q;
      en_d        = we_ctrl ? WriteData[0] : en_q;
      clr         = we_ctrl && WriteData[1];
      period_sh_d = we_period ? WriteData[CNT_W-1:0] : period_sh_q;
      wrap        = en_q && (cnt_q == period_act_q);
      // A clear or a disabled counter reloads the active set as well as a wrap does.
      load_act    = clr || !en_q || wrap;
      cnt_d       = (clr || !en_q || wrap) ? '0 : cnt_q + 1'b1;
      wraps_d     = (wrap && !clr) ? wraps_q + 16'd1 : wraps_q;
      period_act_d = load_act ? period_sh_d : period_act_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds_q       <= '0;
         en_q         <= 1'b0;
         cnt_q        <= '0;
         wraps_q      <= '0;
         period_sh_q  <= PERIOD_RST;
         period_act_q <= PERIOD_RST;
      end else begin
         leds_q       <= leds_d;
         en_q         <= en_d;
         cnt_q        <= cnt_d;
         wraps_q      <= wraps_d;
         period_sh_q  <= period_sh_d;
         period_act_q <= period_act_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             we_duty;
         logic [CNT_W-1:0] duty_sh_d, duty_act_d;
         logic             pwm_d;

         // The shadow written on this edge is what a same-edge reload picks up.
         always_comb begin
            we_duty    = wr && (widx == 4'(4 + gi));
            duty_sh_d  = we_duty ? WriteData[CNT_W-1:0] : duty_sh_q[gi];
            duty_act_d = load_act ? duty_sh_d : duty_act_q[gi];
            pwm_d      = en_q && (cnt_q < duty_act_q[gi]);
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               duty_sh_q[gi]  <= '0;
               duty_act_q[gi] <= '0;
               pwm_q[gi]      <= 1'b0;
            end else begin
               duty_sh_q[gi]  <= duty_sh_d;
               duty_act_q[gi] <= duty_act_d;
               pwm_q[gi]      <= pwm_d;
            end
         end
      end
   endgenerate

   always_comb begin
      ReadData = '0;
      if (hit) begin
         case (widx)
            4'd0:    ReadData = {28'd0, leds_q};
            4'd1:    ReadData = {31'd0, en_q};
            4'd2:    ReadData = 32'(period_sh_q);
            4'd3:    ReadData = {16'd0, wraps_q};
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (widx == 4'(4 + i)) ReadData = 32'(duty_sh_q[i]);
               end
            end
         endcase
      end
   end

   assign leds    = leds_q;
   assign pwm_out = pwm_q;
endmodule
